// File: rtl/rtc_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rtc_time_ctrl
//  Brief    : Real-time clock controller. Divides clk down to a 1 Hz tick,
//             keeps 24 h binary hour/min/second time with carries, and offers
//             a button-driven set mode (RUN -> hour -> min -> sec -> RUN).
//             Optional alarm compare is built when ALARM_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module rtc_time_ctrl #(
   parameter int CLK_DIV = 50_000_000,   // system clocks per second tick (>= 2)
   parameter int DIV_W   = 26            // prescaler width, 2**DIV_W >= CLK_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
`ifdef ALARM_EN
   input  logic       alarm_set,
   output logic       alarm_hit,
`endif
   output logic [5:0] hour,
   output logic [5:0] min,
   output logic [5:0] second,
   output logic [1:0] edit_sel,
   output logic       sec_pulse
);

   // State encoding doubles as the edit_sel display code.
   localparam logic [1:0] c_ST_RUN      = 2'd0;
   localparam logic [1:0] c_ST_SET_HOUR = 2'd1;
   localparam logic [1:0] c_ST_SET_MIN  = 2'd2;
   localparam logic [1:0] c_ST_SET_SEC  = 2'd3;

   localparam logic [DIV_W-1:0] c_DIV_MAX = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_state;
   logic [5:0]       r_hour;
   logic [5:0]       r_min;
   logic [5:0]       r_sec;
   logic             r_sec_pulse;

   logic             w_tick;
   logic             w_sec_wrap;
   logic             w_min_wrap;
   logic [5:0]       w_inc_hour;
   logic [5:0]       w_inc_min;
   logic [5:0]       w_inc_sec;
   logic [5:0]       w_tick_hour;
   logic [5:0]       w_tick_min;

   // Tick detection plus wrapping increments shared by the carry chain and set mode.
   always_comb begin
      w_tick      = (r_state == c_ST_RUN) && (r_div == c_DIV_MAX);
      w_sec_wrap  = (r_sec == 6'd59);
      w_min_wrap  = (r_min == 6'd59);
      w_inc_sec   = w_sec_wrap ? 6'd0 : r_sec + 6'd1;
      w_inc_min   = w_min_wrap ? 6'd0 : r_min + 6'd1;
      w_inc_hour  = (r_hour == 6'd23) ? 6'd0 : r_hour + 6'd1;
      w_tick_min  = w_sec_wrap ? w_inc_min : r_min;
      w_tick_hour = (w_sec_wrap && w_min_wrap) ? w_inc_hour : r_hour;
   end

   // Prescaler, timekeeping, set-mode FSM and the tick strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_div       <= '0;
         r_state     <= c_ST_RUN;
         r_hour      <= 6'd0;
         r_min       <= 6'd0;
         r_sec       <= 6'd0;
         r_sec_pulse <= 1'b0;
      end else begin
         r_sec_pulse <= w_tick;

         // Count only while running; any SET state parks the count at zero so
         // the first tick after returning to RUN is a full period away.
         if (r_state == c_ST_RUN) begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
         end else begin
            r_div <= '0;
         end

         if (w_tick) begin
            r_sec  <= w_inc_sec;
            r_min  <= w_tick_min;
            r_hour <= w_tick_hour;
         end

         // btn_mode has priority; a simultaneous btn_inc is dropped.
         if (btn_mode) begin
            r_state <= r_state + 2'd1;
         end else if (btn_inc) begin
            case (r_state)
               c_ST_SET_HOUR: r_hour <= w_inc_hour;
               c_ST_SET_MIN:  r_min  <= w_inc_min;
               c_ST_SET_SEC:  r_sec  <= w_inc_sec;
               default:       ;
            endcase
         end
      end
   end

`ifdef ALARM_EN
   logic [5:0] r_alarm_hour;
   logic [5:0] r_alarm_min;
   logic       r_armed;
   logic       r_alarm_hit;

   // Alarm capture and match; the hit lines up with sec_pulse for the matching update.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_alarm_hour <= 6'd0;
         r_alarm_min  <= 6'd0;
         r_armed      <= 1'b0;
         r_alarm_hit  <= 1'b0;
      end else begin
         r_alarm_hit <= w_tick && r_armed && (w_inc_sec == 6'd0) &&
                        (w_tick_min == r_alarm_min) && (w_tick_hour == r_alarm_hour);
         if (alarm_set) begin
            r_alarm_hour <= r_hour;
            r_alarm_min  <= r_min;
            r_armed      <= 1'b1;
         end
      end
   end

   assign alarm_hit = r_alarm_hit;
`endif

   assign hour      = r_hour;
   assign min       = r_min;
   assign second    = r_sec;
   assign edit_sel  = r_state;
   assign sec_pulse = r_sec_pulse;

endmodule
`default_nettype wire

// File: tb/tb_rtc_time_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rtc_time_ctrl
//  Brief    : Self-checking bench for rtc_time_ctrl (CLK_DIV=4). Keeps time
//             as a seconds-of-day integer and compares every cycle, with
//             directed scenarios and literal checks followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rtc_time_ctrl;

   localparam int CLK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic [5:0] hour;
   logic [5:0] min;
   logic [5:0] second;
   logic [1:0] edit_sel;
   logic       sec_pulse;

   int n_checks = 0;
   int n_fail   = 0;

   rtc_time_ctrl #(.CLK_DIV(CLK_DIV), .DIV_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_mode  (btn_mode),
      .btn_inc   (btn_inc),
      .hour      (hour),
      .min       (min),
      .second    (second),
      .edit_sel  (edit_sel),
      .sec_pulse (sec_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time of day in seconds, a mode number, and the number
   // of RUN cycles elapsed since the last second boundary.
   int m_t     = 0;
   int m_mode  = 0;
   int m_cnt   = 0;
   bit m_pulse = 1'b0;
   bit m_valid = 1'b0;

   always @(posedge clk) begin : model
      int h, mi, s;
      bit tick;
      if (rst) begin
         m_t = 0; m_mode = 0; m_cnt = 0; m_pulse = 1'b0; m_valid = 1'b1;
      end else begin
         tick    = (m_mode == 0) && (m_cnt == CLK_DIV - 1);
         m_pulse = tick;
         if (tick) m_t = (m_t + 1) % 86400;
         m_cnt = (m_mode == 0) ? (m_cnt + 1) % CLK_DIV : 0;
         if (btn_mode) begin
            m_mode = (m_mode + 1) % 4;
         end else if (btn_inc && m_mode != 0) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (m_mode == 1) h  = (h + 1) % 24;
            if (m_mode == 2) mi = (mi + 1) % 60;
            if (m_mode == 3) s  = (s + 1) % 60;
            m_t = h * 3600 + mi * 60 + s;
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("hour",      int'(hour),      m_t / 3600);
         check("min",       int'(min),       (m_t / 60) % 60);
         check("second",    int'(second),    m_t % 60);
         check("edit_sel",  int'(edit_sel),  m_mode);
         check("sec_pulse", int'(sec_pulse), int'(m_pulse));
      end
   end

   int pulses;

   // One clock cycle with the given inputs; returns just after the edge.
   task automatic cyc(input logic m, input logic i, input logic r);
      @(negedge clk);
      btn_mode = m;
      btn_inc  = i;
      rst      = r;
      @(posedge clk);
      #1;
      if (sec_pulse) pulses++;
   endtask

   task automatic incs(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      // Scenario 1: reset then free run.
      cyc(1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
      check("rst_hour", int'(hour), 0);
      check("rst_edit", int'(edit_sel), 0);
      check("rst_pulse", int'(sec_pulse), 0);
      pulses = 0;
      for (int k = 0; k < 12; k++) cyc(1'b0, 1'b0, 1'b0);
      check("run12_second", int'(second), 3);
      check("run12_min", int'(min), 0);
      check("run12_pulses", pulses, 3);

      // Scenario 2: set 23:59:59 and roll over.
      cyc(1'b1, 1'b0, 1'b0);
      check("set_hour_sel", int'(edit_sel), 1);
      incs(23);
      check("set_hour23", int'(hour), 23);
      cyc(1'b1, 1'b0, 1'b0);
      incs(59);
      cyc(1'b1, 1'b0, 1'b0);
      incs(56);
      check("set_sec59", int'(second), 59);
      cyc(1'b1, 1'b0, 1'b0);
      check("back_run", int'(edit_sel), 0);
      pulses = 0;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
      check("no_early_tick", int'(second), 59);
      cyc(1'b0, 1'b0, 1'b0);
      check("wrap_hour", int'(hour), 0);
      check("wrap_min", int'(min), 0);
      check("wrap_sec", int'(second), 0);
      check("wrap_pulses", pulses, 1);

      // Scenario 3: min 59 -> 0 with no carry into hour.
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      incs(59);
      check("min59", int'(min), 59);
      cyc(1'b0, 1'b1, 1'b0);
      check("min_wrap", int'(min), 0);
      check("min_wrap_hour", int'(hour), 0);
      check("min_wrap_sel", int'(edit_sel), 2);

      // Scenario 4: mode and inc together at hour 5.
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      incs(5);
      cyc(1'b1, 1'b1, 1'b0);
      check("both_sel", int'(edit_sel), 2);
      check("both_hour", int'(hour), 5);

      // Scenario 5: reset out of SET_SEC at 12:34:56.
      incs(34);
      cyc(1'b1, 1'b0, 1'b0);
      incs(56);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      incs(7);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("pre_rst_hour", int'(hour), 12);
      check("pre_rst_min", int'(min), 34);
      check("pre_rst_sec", int'(second), 56);
      check("pre_rst_sel", int'(edit_sel), 3);
      cyc(1'b0, 1'b0, 1'b1);
      check("post_rst_hour", int'(hour), 0);
      check("post_rst_sec", int'(second), 0);
      check("post_rst_sel", int'(edit_sel), 0);
      pulses = 0;
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0);
      check("post_rst_pulses", pulses, 0);

      // Randomized traffic against the model.
      for (int k = 0; k < 6000; k++) begin
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 499) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
